// File: rtl/audio_pwm_mixer_if.sv
// Configuration write bus between the sound sequencer and audio_pwm_mixer.
// The sequencer drives the write strobe and data; the mixer reports unapplied writes.
interface audio_pwm_mixer_if #(
  parameter int CHANNELS = 4,
  parameter int CW       = 32,
  parameter int VOL_BITS = 4
);
  localparam int CHW = $clog2(CHANNELS);

  // wr_en is a one-cycle strobe with no ready: every write is taken in the cycle it is
  // presented (out-of-range wr_ch is dropped) and upd_pending[ch] stays high until applied.
  logic                wr_en;
  logic [CHW-1:0]      wr_ch;
  logic [CW-1:0]       wr_period;
  logic [CW-1:0]       wr_duty;
  logic [VOL_BITS-1:0] wr_vol;
  logic [CHANNELS-1:0] upd_pending;

  modport master (
    output wr_en,
    output wr_ch,
    output wr_period,
    output wr_duty,
    output wr_vol,
    input  upd_pending
  );

  modport slave (
    input  wr_en,
    input  wr_ch,
    input  wr_period,
    input  wr_duty,
    input  wr_vol,
    output upd_pending
  );
endinterface

// File: rtl/audio_pwm_mixer.sv
// Multi-channel tone mixer: per-channel double-buffered square-wave generators whose
// volume-weighted sum is re-encoded onto a single fixed-rate PWM carrier.
module audio_pwm_mixer #(
  parameter  int CHANNELS = 4,
  parameter  int CW       = 32,
  parameter  int VOL_BITS = 4,
  localparam int VMAX     = (1 << VOL_BITS) - 1,
  localparam int LMAX     = CHANNELS * VMAX,
  localparam int LW       = $clog2(LMAX + 1),
  localparam int CHW      = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] ch_en,
  audio_pwm_mixer_if.slave    cfg,
  output logic [CHANNELS-1:0] tone,
  output logic [LW-1:0]       level,
  output logic                pwm
);

  localparam logic [CHW:0]  CH_LIM  = (CHW + 1)'(CHANNELS);
  localparam logic [LW-1:0] CC_LAST = LW'(LMAX - 1);

  // Active configuration drives the tone; pending holds the next one until a boundary.
  logic [CW-1:0]       per_a  [CHANNELS];
  logic [CW-1:0]       duty_a [CHANNELS];
  logic [VOL_BITS-1:0] vol_a  [CHANNELS];
  logic [CW-1:0]       per_p  [CHANNELS];
  logic [CW-1:0]       duty_p [CHANNELS];
  logic [VOL_BITS-1:0] vol_p  [CHANNELS];
  logic [CW-1:0]       cnt    [CHANNELS];
  logic [CHANNELS-1:0] pend;

  logic                wr_ok;
  logic [CHANNELS-1:0] wrap;
  logic [CHANNELS-1:0] hit;
  logic [CHANNELS-1:0] apply;
  logic [LW-1:0]       sum;
  logic [LW-1:0]       cc;

  assign wr_ok = cfg.wr_en && ({1'b0, cfg.wr_ch} < CH_LIM);

  // A boundary is a wrap of an enabled channel, or any cycle of a disabled channel
  // holding a pending write. A write landing on a boundary goes straight to active.
  always_comb begin
    wrap  = '0;
    hit   = '0;
    apply = '0;
    tone  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wrap[i]  = ch_en[i] && (cnt[i] >= per_a[i]);
      hit[i]   = wr_ok && (cfg.wr_ch == CHW'(i));
      apply[i] = wrap[i] || (!ch_en[i] && pend[i]);
      tone[i]  = ch_en[i] && (cnt[i] < duty_a[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        per_a[i]  <= '0;
        duty_a[i] <= '0;
        vol_a[i]  <= '0;
        per_p[i]  <= '0;
        duty_p[i] <= '0;
        vol_p[i]  <= '0;
        cnt[i]    <= '0;
      end
      pend <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!ch_en[i] || wrap[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end

        if (hit[i] && apply[i]) begin
          per_a[i]  <= cfg.wr_period;
          duty_a[i] <= cfg.wr_duty;
          vol_a[i]  <= cfg.wr_vol;
          pend[i]   <= 1'b0;
        end else if (apply[i] && pend[i]) begin
          per_a[i]  <= per_p[i];
          duty_a[i] <= duty_p[i];
          vol_a[i]  <= vol_p[i];
          pend[i]   <= 1'b0;
        end else if (hit[i]) begin
          per_p[i]  <= cfg.wr_period;
          duty_p[i] <= cfg.wr_duty;
          vol_p[i]  <= cfg.wr_vol;
          pend[i]   <= 1'b1;
        end
      end
    end
  end

  assign cfg.upd_pending = pend;

  always_comb begin
    sum = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (tone[i]) begin
        sum = sum + LW'(vol_a[i]);
      end
    end
  end

  // Level is sampled only at the last carrier step so each carrier cycle is one clean duty.
  always_ff @(posedge clk) begin
    if (rst) begin
      cc    <= '0;
      level <= '0;
    end else if (cc == CC_LAST) begin
      cc    <= '0;
      level <= sum;
    end else begin
      cc <= cc + LW'(1);
    end
  end

  assign pwm = (cc < level);

endmodule

// File: doc/audio_pwm_mixer.md
Name: audio_pwm_mixer

Overview:
- Multi-channel successor to the single-channel audio PWM.
- Contains CHANNELS independent tone generators. Each has its own period, duty and volume, with glitch-free double-buffered updates applied only at that channel's period boundary.
- Active channel tones are summed by volume into a level, re-encoded onto one fixed-rate PWM carrier, and drive the board audio pin.
- Sits between the game sound sequencer (config writes) and the audio output pin.

Parameters:
- CHANNELS, 4, number of tone generators (>=2).
- CW, 32, width of the period and duty counters/registers.
- VOL_BITS, 4, per-channel volume width; VMAX = 2^VOL_BITS-1.
- Derived (not overridable): LMAX = CHANNELS*VMAX; LW = $clog2(LMAX+1); CHW = $clog2(CHANNELS).

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  reset.
- ch_en  in  CHANNELS  per-channel enable.
- wr_en  in  1  config write strobe, one cycle per write.
- wr_ch  in  CHW  target channel.
- wr_period  in  CW  new period (channel cycle length = wr_period+1 clocks).
- wr_duty  in  CW  new high time in clocks.
- wr_vol  in  VOL_BITS  new volume.
- upd_pending  out  CHANNELS  bit i=1 while channel i holds an unapplied write.
- tone  out  CHANNELS  raw per-channel square waves.
- level  out  LW  latched mix level driving the carrier.
- pwm  out  1  mixed PWM audio output.

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- On reset, all registers clear: counters, active and pending config, pending flags, carrier counter, level. Outputs upd_pending=0, tone=0, level=0, pwm=0. Reset mid-operation discards pending writes and aborts the current cycle at once.
- Per channel i, registers:
  - active period/duty/vol (P, D, V);
  - pending period/duty/vol;
  - pend flag;
  - counter cnt.
- Channel counting:
  - ch_en[i]=1: if cnt >= P, then cnt<=0 ("wrap"); else cnt<=cnt+1.
  - ch_en[i]=0: cnt held at 0, no wrap.
- tone[i] = ch_en[i] && (cnt < D), combinational from registers.
  - D=0 gives constant 0.
  - D > P gives constant 1.
  - P=0 wraps every enabled cycle; counter stays 0.
- Write handling:
  - wr_en with wr_ch >= CHANNELS: ignored.
  - Otherwise the data loads into the pending registers of wr_ch and pend is set.
- Apply: in a cycle where pend=1 and (wrap occurs or ch_en[i]=0), active<=pending and pend<=0. New values take effect in the following cycle; cnt restarts at 0.
- Simultaneous write and apply on the same channel: write data bypasses straight into active, and pend ends at 0.
- A second write before apply overwrites pending; the last write wins.
- upd_pending = pend flags.
- Mix: sum = sum over i of (tone[i] ? V_i : 0). Range 0..LMAX, computed at LW bits with no overflow.
- Carrier:
  - Counter cc runs 0..LMAX-1 then wraps to 0 (LMAX clocks per carrier cycle).
  - In the cycle where cc==LMAX-1, level<=sum. Level is constant for a whole carrier cycle.
  - pwm = (cc < level), combinational from registers. level=0 gives always low; level=LMAX gives always high.
- Carrier runs regardless of ch_en; all channels disabled drives level to 0 after the next carrier boundary.

Test Plan:
- Reset check: assert rst 3 cycles mid-activity -> all outputs 0 next cycle; upd_pending=0; first post-reset tone edge is at cnt=0.
- Single-channel tone: write ch0 P=9, D=3, V=15, enable ch0 only. With defaults, LMAX=60, so:
  - tone[0] repeats 3 high / 7 low;
  - level reads 15 or 0 depending on tone at carrier boundary;
  - with level=15, pwm is high for 15 of 60 clocks.
- Double buffering: ch0 running P=9, write P=4, D=2 at cnt=5 -> upd_pending[0]=1 until the cycle cnt=9; new 5-cycle pattern starts next cycle with no truncated pulse.
- Collision/bypass: write ch1 in the exact cycle its cnt==P -> new values active next cycle; upd_pending[1] never observed 1. Write to ch index >= CHANNELS (CHANNELS=3 build, wr_ch=3) -> no state change.
- Full mix: all 4 channels P=0, D=1, V=15 -> level=60 after first carrier boundary; pwm constant 1. Then disable all -> level=0 after next boundary; pwm constant 0.
- Edge configs: D=0 -> tone 0; D=P+5 -> tone constant 1; disabled channel write applies in 1 cycle (upd_pending pulses for one cycle).
